// File: rtl/instr_fetch_ctrl_if.sv
// Decode-side valid/ready handshake carrying the fetched
// instruction and its PC out of the prefetch queue.
interface instr_fetch_ctrl_if #(
  parameter int DW = 32,
  parameter int IW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [DW-1:0] out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch PC owner + circular prefetch queue toward decode.
// Optional FETCH_PERF_CNT_EN adds fetch/stall counters.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  instr_fetch_ctrl_if.master dec
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FULL
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     qpc_q  [QUEUE_DEPTH];
  logic [31:0]     qins_q [QUEUE_DEPTH];

  logic push;
  logic pop;
  logic last_slot;

  assign imem_addr     = pc_q;
  assign dec.out_valid = (cnt_q != '0) && !redirect_valid;
  assign dec.out_pc    = qpc_q[rd_q];
  assign dec.out_instr = qins_q[rd_q];

  assign push      = (state_q == FETCH) && !redirect_valid;
  assign pop       = dec.out_valid && dec.out_ready;
  assign last_slot = cnt_q == CW'(QUEUE_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qpc_q[i]  <= '0;
        qins_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Wrong-path entries are dropped by collapsing the queue.
      state_q <= FETCH;
      pc_q    <= {redirect_pc[31:2], 2'b00};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        qpc_q[wr_q]  <= pc_q;
        qins_q[wr_q] <= imem_instr;
        wr_q         <= wr_q + 1'b1;
        pc_q         <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      unique case (state_q)
        BOOT:  state_q <= FETCH;
        FETCH: if (!pop && last_slot) state_q <= FULL;
        FULL:  if (pop) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && fetched_q != '1) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (state_q == FULL && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
`endif

endmodule
